// File: rtl/regfile_op_sequencer.sv
// Serialises ADD/SUB/MOV/LOADI commands onto a single register-file port:
// read both sources, compute, write one cycle, then hand the result back.
module regfile_op_sequencer #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 5,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rf_mode,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_value,
  output logic              res_carry,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOADI = 2'b11;
  localparam int CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

  state_t            state, state_next;
  logic [1:0]        op;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              read_done;
  logic [DATA_W:0]   sum, diff;
  logic [DATA_W-1:0] result;
  logic              carry;

  assign accept    = cmd_valid && (state == IDLE);
  assign read_done = (cnt == CNT_W'(RD_WAIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = (cmd_op == OP_LOADI) ? WRITE : READ;
      READ:  if (read_done) state_next = WRITE;
      WRITE: state_next = RESP;
      RESP:  if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Borrow of SUB falls out as the top bit of the extended difference.
  always_comb begin
    sum    = {1'b0, rf_rdata1} + {1'b0, rf_rdata2};
    diff   = {1'b0, rf_rdata1} - {1'b0, rf_rdata2};
    result = rf_rdata1;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin result = sum[DATA_W-1:0];  carry = sum[DATA_W];  end
      OP_SUB: begin result = diff[DATA_W-1:0]; carry = diff[DATA_W]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op        <= 2'b00;
      cnt       <= '0;
      rf_raddr1 <= '0;
      rf_raddr2 <= '0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      res_carry <= 1'b0;
    end else if (accept) begin
      op        <= cmd_op;
      cnt       <= '0;
      rf_raddr1 <= cmd_rs1;
      rf_raddr2 <= cmd_rs2;
      rf_waddr  <= cmd_rd;
      if (cmd_op == OP_LOADI) begin
        rf_wdata  <= cmd_imm;
        res_carry <= 1'b0;
      end
    end else if (state == READ) begin
      if (read_done) begin
        rf_wdata  <= result;
        res_carry <= carry;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // The returned value is by construction the word that was written.
  assign res_value = rf_wdata;
  assign rf_mode   = (state == WRITE);
  assign res_valid = (state == RESP);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Drives directed and random commands into the sequencer against a bench-side
// register file and a reference model of register contents and results.
module tb_regfile_op_sequencer;
  parameter int RD_WAIT = 1;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [DATA_W-1:0] cmd_imm;
  logic              rf_mode;
  logic [ADDR_W-1:0] rf_waddr, rf_raddr1, rf_raddr2;
  logic [DATA_W-1:0] rf_wdata, rf_rdata1, rf_rdata2;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_value;
  logic              res_carry;
  logic              busy;

  logic [DATA_W-1:0] mem [32];
  logic [DATA_W-1:0] ref_mem [32];
  logic              mem_clr;
  logic              junk;
  int                wr_count;
  int                exp_writes;
  int                checks;
  int                failures;

  regfile_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .rf_mode(rf_mode), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_value(res_value), .res_carry(res_carry), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Corrupted read data during early READ cycles must never reach the result.
  assign rf_rdata1 = junk ? ~mem[rf_raddr1] : mem[rf_raddr1];
  assign rf_rdata2 = junk ? ~mem[rf_raddr2] : mem[rf_raddr2];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      wr_count <= 0;
    end else if (rf_mode) begin
      mem[rf_waddr] <= rf_wdata;
      wr_count      <= wr_count + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [15:0] imm, input int hold,
                         input bit early_rr, input bit abort, input bit poke);
    logic [15:0] a, b, ev;
    logic        ec;
    int          s, lat, guard;
    a = ref_mem[rs1];
    b = ref_mem[rs2];
    case (op)
      2'd0: begin s = int'(a) + int'(b); ev = 16'(s % 65536); ec = (s > 65535); end
      2'd1: begin s = int'(a) - int'(b) + 65536; ev = 16'(s % 65536); ec = (a < b); end
      2'd2: begin ev = a; ec = 1'b0; end
      default: begin ev = imm; ec = 1'b0; end
    endcase
    lat = (op == 2'd3) ? 1 : RD_WAIT + 1;

    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_cmd", cmd_ready, 1);
    res_ready = early_rr;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_rd = 5'($urandom); cmd_rs1 = 5'($urandom); cmd_rs2 = 5'($urandom);
    cmd_imm = 16'($urandom); cmd_op = 2'($urandom);

    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      chk("rf_mode", rf_mode, 32'(k == lat - 1));
      chk("res_valid", res_valid, 32'(k == lat));
      chk("busy", busy, 1);
      if (op != 2'd3 && k < RD_WAIT) begin
        chk("raddr1", rf_raddr1, rs1);
        chk("raddr2", rf_raddr2, rs2);
      end
      if (k == lat - 1) begin
        chk("waddr", rf_waddr, rd);
        chk("wdata", rf_wdata, ev);
        if (abort) begin
          #2 rst_n = 1'b0;
          #1;
          chk("abort_mode", rf_mode, 0);
          chk("abort_busy", busy, 0);
          chk("abort_ready", cmd_ready, 1);
          chk("abort_valid", res_valid, 0);
          chk("abort_waddr", rf_waddr, 0);
          chk("abort_wdata", rf_wdata, 0);
          chk("abort_raddr1", rf_raddr1, 0);
          chk("abort_value", res_value, 0);
          chk("abort_carry", res_carry, 0);
          junk = 1'b0;
          res_ready = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          $display("CMD op=%0d rd=%0d aborted by reset", op, rd);
          return;
        end
      end
      junk = (op != 2'd3) && (k < RD_WAIT - 1);
    end
    chk("res_value", res_value, ev);
    chk("res_carry", res_carry, ec);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      cmd_valid = poke;
      cmd_op = 2'd3; cmd_rd = 5'd6; cmd_imm = 16'hBEEF;
      @(posedge clk);
      #1;
      chk("hold_valid", res_valid, 1);
      chk("hold_value", res_value, ev);
      chk("hold_ready", cmd_ready, 0);
      chk("hold_mode", rf_mode, 0);
    end
    if (!early_rr) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      res_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("done_valid", res_valid, 0);
    chk("done_ready", cmd_ready, 1);
    res_ready = 1'b0;
    ref_mem[rd] = ev;
    exp_writes++;
    $display("CMD op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h value=%h carry=%0d", op, rd, rs1, rs2, imm, ev, ec);
  endtask

  initial begin
    checks = 0; failures = 0; exp_writes = 0;
    rst_n = 1'b0; mem_clr = 1'b1; junk = 1'b0;
    cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mode", rf_mode, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_value", res_value, 0);
    chk("rst_carry", res_carry, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_raddr1", rf_raddr1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_clr = 1'b0;

    run_cmd(2'd3, 5'd0, 5'd0, 5'd0, 16'h1232, 0, 1'b0, 1'b0, 1'b0);
    run_cmd(2'd3, 5'd1, 5'd0, 5'd0, 16'h1263, 0, 1'b0, 1'b0, 1'b0);
    run_cmd(2'd0, 5'd2, 5'd0, 5'd1, 16'h0000, 5, 1'b0, 1'b0, 1'b1);
    chk("add_r2", mem[2], 16'h2495);
    chk("no_write_r6", mem[6], 16'h0000);
    run_cmd(2'd1, 5'd3, 5'd0, 5'd1, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
    chk("sub_r3", mem[3], 16'hFFCF);
    run_cmd(2'd3, 5'd4, 5'd0, 5'd0, 16'hFFFF, 0, 1'b1, 1'b0, 1'b0);
    run_cmd(2'd3, 5'd5, 5'd0, 5'd0, 16'h0001, 0, 1'b0, 1'b0, 1'b0);
    run_cmd(2'd0, 5'd8, 5'd4, 5'd5, 16'h0000, 1, 1'b0, 1'b0, 1'b0);
    chk("add_wrap_r8", mem[8], 16'h0000);
    run_cmd(2'd2, 5'd7, 5'd2, 5'd0, 16'h0000, 0, 1'b0, 1'b1, 1'b0);
    chk("abort_r7", mem[7], 16'h0000);
    run_cmd(2'd3, 5'd9, 5'd0, 5'd0, 16'hA5A5, 0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int  hold;
      bit  early, poke;
      hold  = int'($urandom_range(0, 3));
      early = (hold == 0) && ($urandom_range(0, 1) == 1);
      poke  = (hold > 0) && ($urandom_range(0, 1) == 1);
      run_cmd(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 5'($urandom),
              16'($urandom), hold, early, 1'b0, poke);
    end

    @(negedge clk);
    for (int i = 0; i < 32; i++) chk($sformatf("mem_r%0d", i), mem[i], ref_mem[i]);
    chk("write_count", wr_count, exp_writes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
